// File: rtl/gelato_operand_collector.sv
// gelato_operand_collector: latches one decoded instruction, fetches its used
// source registers from the register file one read at a time (lowest slot
// first), then holds the instruction and operands until execute consumes them.
module gelato_operand_collector #(
  parameter int NUM_RS     = 3,
  parameter int INST_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int WARP_ID_W  = 4,
  parameter int WARP_REG_W = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INST_W-1:0]              in_inst,
  input  logic [WARP_ID_W-1:0]           in_warp,
  input  logic [NUM_RS*REG_ADDR_W-1:0]   in_rs_addr,
  input  logic [NUM_RS-1:0]              in_rs_use,
  output logic                           rf_req_valid,
  input  logic                           rf_req_ready,
  output logic [WARP_ID_W-1:0]           rf_req_warp,
  output logic [REG_ADDR_W-1:0]          rf_req_addr,
  input  logic                           rf_rsp_valid,
  input  logic [WARP_REG_W-1:0]          rf_rsp_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INST_W-1:0]              out_inst,
  output logic [NUM_RS*WARP_REG_W-1:0]   out_src
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, ISSUE, DRAIN} state_t;

  state_t                         state_reg, state_next;
  logic [PTR_W-1:0]               ptr_reg, ptr_next;
  logic [INST_W-1:0]              inst_reg;
  logic [WARP_ID_W-1:0]           warp_reg;
  logic [NUM_RS*REG_ADDR_W-1:0]   rs_addr_reg;
  logic [NUM_RS-1:0]              rs_use_reg;
  logic [REG_ADDR_W-1:0]          rs_addr_arr [NUM_RS];

  logic                           accept;
  logic                           load_slot;
  logic                           first_found, after_found;
  logic [PTR_W-1:0]               first_idx, after_idx;

  // Lowest used slot of the offered instruction, and lowest used slot above the current pointer.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    after_found = 1'b0;
    after_idx   = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (in_rs_use[i]) begin
        first_found = 1'b1;
        first_idx   = PTR_W'(i);
      end
      if (rs_use_reg[i] && (i > int'(ptr_reg))) begin
        after_found = 1'b1;
        after_idx   = PTR_W'(i);
      end
    end
  end

  // Handshake outputs; flush in IDLE suppresses acceptance for that cycle.
  assign in_ready     = (state_reg == IDLE) && !flush && !rst;
  assign rf_req_valid = (state_reg == REQ);
  assign out_valid    = (state_reg == ISSUE);
  assign rf_req_warp  = warp_reg;
  assign rf_req_addr  = rs_addr_arr[ptr_reg];
  assign out_inst     = inst_reg;

  // Next-state logic; flush is evaluated before every other event.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    accept     = 1'b0;
    load_slot  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          ptr_next   = first_idx;
          state_next = first_found ? REQ : ISSUE;
        end
      end
      REQ: begin
        // A request taken in the flush cycle still has a response on its way.
        if (flush)             state_next = rf_req_ready ? DRAIN : IDLE;
        else if (rf_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_next = rf_rsp_valid ? IDLE : DRAIN;
        end else if (rf_rsp_valid) begin
          load_slot = 1'b1;
          if (after_found) begin
            ptr_next   = after_idx;
            state_next = REQ;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (flush || out_ready) state_next = IDLE;
      end
      DRAIN: begin
        if (rf_rsp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and slot pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Instruction context captured on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_reg    <= '0;
      warp_reg    <= '0;
      rs_addr_reg <= '0;
      rs_use_reg  <= '0;
    end else if (accept) begin
      inst_reg    <= in_inst;
      warp_reg    <= in_warp;
      rs_addr_reg <= in_rs_addr;
      rs_use_reg  <= in_rs_use;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RS; gi++) begin : g_slot
      logic [WARP_REG_W-1:0] src_reg;

      assign rs_addr_arr[gi] = rs_addr_reg[gi*REG_ADDR_W +: REG_ADDR_W];
      assign out_src[gi*WARP_REG_W +: WARP_REG_W] = src_reg;

      // Operand slot: cleared per instruction so unused slots read as zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         src_reg <= '0;
        else if (accept)                                 src_reg <= '0;
        else if (load_slot && (ptr_reg == PTR_W'(gi)))   src_reg <= rf_rsp_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_gelato_operand_collector.sv
// Randomized self-checking bench for gelato_operand_collector with a
// register-file responder and an instruction-level operand model.
`timescale 1ns/1ps
module tb_gelato_operand_collector;

  localparam int NRS = 3;
  localparam int IW  = 64;
  localparam int RAW = 5;
  localparam int WIW = 4;
  localparam int WRW = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IW-1:0]     in_inst = '0;
  logic [WIW-1:0]    in_warp = '0;
  logic [NRS*RAW-1:0] in_rs_addr = '0;
  logic [NRS-1:0]    in_rs_use = '0;
  logic              rf_req_valid;
  logic              rf_req_ready = 1'b0;
  logic [WIW-1:0]    rf_req_warp;
  logic [RAW-1:0]    rf_req_addr;
  logic              rf_rsp_valid = 1'b0;
  logic [WRW-1:0]    rf_rsp_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [IW-1:0]     out_inst;
  logic [NRS*WRW-1:0] out_src;

  int checks = 0;
  int errors = 0;
  int spur_pct = 0;
  logic [WRW-1:0] rf_mem [16][32];

  gelato_operand_collector #(
    .NUM_RS(NRS), .INST_W(IW), .REG_ADDR_W(RAW), .WARP_ID_W(WIW), .WARP_REG_W(WRW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_warp(in_warp),
    .in_rs_addr(in_rs_addr), .in_rs_use(in_rs_use),
    .rf_req_valid(rf_req_valid), .rf_req_ready(rf_req_ready),
    .rf_req_warp(rf_req_warp), .rf_req_addr(rf_req_addr),
    .rf_rsp_valid(rf_rsp_valid), .rf_rsp_data(rf_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WRW-1:0] junk();
    logic [WRW-1:0] v;
    for (int j = 0; j < WRW/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Offer one instruction for a single cycle (no checks).
  task automatic offer(input logic [IW-1:0] inst, input logic [WIW-1:0] warp,
                       input logic [NRS*RAW-1:0] addrs, input logic [NRS-1:0] use_m);
    in_valid = 1'b1; in_inst = inst; in_warp = warp; in_rs_addr = addrs; in_rs_use = use_m;
    tick;
    in_valid = 1'b0;
  endtask

  // Run one instruction end to end against the operand model; lat = cycles from acceptance to first out_valid.
  task automatic run_inst(input logic [IW-1:0] inst, input logic [WIW-1:0] warp,
                          input logic [NRS*RAW-1:0] addrs, input logic [NRS-1:0] use_m,
                          input int rdy_pct, input int max_dly, input int ordy_pct,
                          input int req_stall, input int out_stall, output int lat);
    logic [WRW-1:0] exp_src [NRS];
    int exp_q[$];
    int exp_a;
    bit pend, deliver, prev_wait, done;
    int pend_cnt, cyc, rs, os;
    logic [RAW-1:0] pend_addr, prev_addr;
    logic [WIW-1:0] prev_warp;
    pend = 0; deliver = 0; prev_wait = 0; done = 0;
    pend_cnt = 0; cyc = 1; rs = req_stall; os = out_stall;
    pend_addr = '0; prev_addr = '0; prev_warp = '0;
    lat = -1;
    for (int i = 0; i < NRS; i++) begin
      exp_src[i] = use_m[i] ? rf_mem[warp][addrs[i*RAW +: RAW]] : '0;
      if (use_m[i]) exp_q.push_back(int'(addrs[i*RAW +: RAW]));
    end
    in_valid = 1'b1; in_inst = inst; in_warp = warp; in_rs_addr = addrs; in_rs_use = use_m;
    flush = 1'b0; rf_rsp_valid = 1'b0; rf_req_ready = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready); end
    tick;
    in_valid = 1'b0; in_inst = {$urandom, $urandom}; in_warp = WIW'($urandom);
    in_rs_addr = NRS*RAW'($urandom); in_rs_use = NRS'($urandom);
    while (!done && cyc < 300) begin
      deliver = 0;
      if (pend && pend_cnt == 0) begin
        rf_rsp_valid = 1'b1; rf_rsp_data = rf_mem[warp][pend_addr]; pend = 0; deliver = 1;
      end else begin
        if (pend) pend_cnt--;
        rf_rsp_valid = !pend && ($urandom_range(99) < spur_pct);
        rf_rsp_data = junk();
      end
      rf_req_ready = (rs > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (rs > 0) rs--;
      out_ready = (os > 0) ? 1'b0 : ($urandom_range(99) < ordy_pct);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready cyc%0d: in_ready=%b required 0", cyc, in_ready); end
      if (rf_req_valid === 1'b1) begin
        checks++;
        if (pend || deliver) begin errors++; $display("FAIL one_outstanding cyc%0d: rf_req_valid=1 with read in flight", cyc); end
        if (prev_wait) begin
          checks++;
          if (rf_req_addr !== prev_addr || rf_req_warp !== prev_warp) begin
            errors++; $display("FAIL req_stable cyc%0d: addr=%0d warp=%0d required addr=%0d warp=%0d",
                               cyc, rf_req_addr, rf_req_warp, prev_addr, prev_warp);
          end
        end
        if (rf_req_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL extra_req cyc%0d: addr=%0d required no request", cyc, rf_req_addr);
          end else begin
            exp_a = exp_q.pop_front();
            if (rf_req_warp !== warp || int'(rf_req_addr) != exp_a) begin
              errors++; $display("FAIL req_order cyc%0d: warp=%0d addr=%0d required warp=%0d addr=%0d",
                                 cyc, rf_req_warp, rf_req_addr, warp, exp_a);
            end
          end
          pend = 1; pend_cnt = $urandom_range(max_dly - 1); pend_addr = rf_req_addr;
        end
        prev_wait = !rf_req_ready; prev_addr = rf_req_addr; prev_warp = rf_req_warp;
      end else begin
        prev_wait = 0;
      end
      if (out_valid === 1'b1) begin
        if (lat < 0) lat = cyc;
        checks++;
        if (out_inst !== inst) begin errors++; $display("FAIL out_inst cyc%0d: got %h required %h", cyc, out_inst, inst); end
        for (int i = 0; i < NRS; i++) begin
          checks++;
          if (out_src[i*WRW +: WRW] !== exp_src[i]) begin
            errors++; $display("FAIL out_src%0d cyc%0d: got low %h required low %h", i, cyc,
                               out_src[i*WRW +: 64], exp_src[i][63:0]);
          end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL missing_reads: %0d reads outstanding required 0", exp_q.size()); end
        if (out_ready) done = 1;
        else if (os > 0) os--;
      end
      tick;
      cyc++;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL timeout: no issue handshake in %0d cycles", cyc); end
    rf_rsp_valid = 1'b0; rf_req_ready = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ready_after_issue: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    $display("inst %h warp %0d use %b lat %0d", inst, warp, use_m, lat);
    tick;
  endtask

  task automatic test_reset;
    in_valid = 1'b1; in_rs_use = '0;
    @(negedge clk);
    checks++;
    if ({in_ready, rf_req_valid, out_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: ready/req/out=%b required 000", {in_ready, rf_req_valid, out_valid});
    end
    checks++;
    if (out_inst !== '0 || out_src !== '0) begin errors++; $display("FAIL reset_data: out_inst=%h required 0", out_inst); end
    checks++;
    if (rf_req_warp !== '0 || rf_req_addr !== '0) begin
      errors++; $display("FAIL reset_req: warp=%0d addr=%0d required 0 0", rf_req_warp, rf_req_addr);
    end
    tick;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: in_ready=%b required 1", in_ready); end
    tick;
  endtask

  task automatic test_no_operands;
    int lat;
    run_inst(64'hA5, 4'd0, '0, 3'b000, 100, 1, 100, 0, 0, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL lat_no_ops: got %0d required 1", lat); end
  endtask

  task automatic test_sparse;
    int lat;
    run_inst(64'h1234_5678_9ABC_DEF0, 4'd2, {5'd7, 5'd20, 5'd3}, 3'b101, 100, 1, 100, 0, 0, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL lat_sparse: got %0d required 5", lat); end
  endtask

  task automatic test_req_stall;
    int lat;
    run_inst(64'hBEEF, 4'd5, {5'd1, 5'd12, 5'd2}, 3'b010, 100, 1, 100, 4, 0, lat);
    checks++;
    if (lat != 7) begin errors++; $display("FAIL lat_req_stall: got %0d required 7", lat); end
  endtask

  task automatic test_out_backpressure;
    int lat;
    run_inst(64'hCAFE, 4'd9, {5'd30, 5'd31, 5'd0}, 3'b011, 100, 1, 100, 0, 3, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL lat_backpressure: got %0d required 5", lat); end
  endtask

  task automatic test_flush;
    int lat;
    // flush in WAIT, response two cycles later
    rf_req_ready = 1'b1;
    offer(64'h11, 4'd1, {5'd0, 5'd0, 5'd9}, 3'b001);
    tick;
    rf_req_ready = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, rf_req_valid, out_valid} !== 3'b000) begin
      errors++; $display("FAIL drain_hold: ready/req/out=%b required 000", {in_ready, rf_req_valid, out_valid});
    end
    tick;
    rf_rsp_valid = 1'b1; rf_rsp_data = {WRW{1'b1}};
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_rsp: in_ready=%b required 0", in_ready); end
    tick;
    rf_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_exit: in_ready=%b required 1", in_ready); end
    tick;
    run_inst(64'h22, 4'd1, {5'd0, 5'd17, 5'd9}, 3'b010, 100, 1, 100, 0, 0, lat);

    // flush in REQ without ready
    rf_req_ready = 1'b0;
    offer(64'h33, 4'd3, {5'd0, 5'd4, 5'd5}, 3'b011);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (rf_req_valid !== 1'b1) begin errors++; $display("FAIL flush_req_valid: rf_req_valid=%b required 1", rf_req_valid); end
    tick;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || rf_req_valid !== 1'b0) begin
      errors++; $display("FAIL flush_req_idle: in_ready=%b req=%b required 1 0", in_ready, rf_req_valid);
    end
    tick;

    // flush in REQ coinciding with ready -> drain
    offer(64'h44, 4'd3, {5'd0, 5'd4, 5'd5}, 3'b001);
    flush = 1'b1; rf_req_ready = 1'b1;
    tick;
    flush = 1'b0; rf_req_ready = 1'b0; rf_rsp_valid = 1'b1; rf_rsp_data = junk();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || rf_req_valid !== 1'b0) begin
      errors++; $display("FAIL flush_req_drain: in_ready=%b req=%b required 0 0", in_ready, rf_req_valid);
    end
    tick;
    rf_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_req_drain_exit: in_ready=%b required 1", in_ready); end
    tick;

    // flush with response in WAIT -> IDLE directly
    rf_req_ready = 1'b1;
    offer(64'h55, 4'd6, {5'd8, 5'd0, 5'd0}, 3'b100);
    tick;
    rf_req_ready = 1'b0; flush = 1'b1; rf_rsp_valid = 1'b1; rf_rsp_data = junk();
    tick;
    flush = 1'b0; rf_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_wait_rsp: in_ready=%b required 1", in_ready); end
    tick;

    // flush together with issue handshake
    offer(64'h66, 4'd0, '0, 3'b000);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_issue: in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
    end
    tick;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_issue_after: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    tick;

    // flush in IDLE blocks acceptance
    in_valid = 1'b1; flush = 1'b1; in_inst = 64'h77; in_rs_use = 3'b000;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: in_ready=%b required 0", in_ready); end
    tick;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_noaccept: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    tick;
    run_inst(64'h88, 4'd7, {5'd1, 5'd2, 5'd3}, 3'b111, 100, 1, 100, 0, 0, lat);
  endtask

  task automatic test_reset_mid;
    rf_req_ready = 1'b1;
    offer(64'h99, 4'd3, {5'd0, 5'd0, 5'd4}, 3'b001);
    tick;
    rf_req_ready = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, rf_req_valid, out_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_hold: ready/req/out=%b required 000", {in_ready, rf_req_valid, out_valid});
    end
    tick;
    rst = 1'b0; rf_rsp_valid = 1'b1; rf_rsp_data = rf_mem[3][4];
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || rf_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release: ready/req/out=%b required 100", {in_ready, rf_req_valid, out_valid});
    end
    checks++;
    if (out_inst !== '0 || out_src !== '0 || rf_req_warp !== '0 || rf_req_addr !== '0) begin
      errors++; $display("FAIL rst_mid_data: out_inst=%h warp=%0d addr=%0d required 0", out_inst, rf_req_warp, rf_req_addr);
    end
    tick;
    rf_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_src !== '0) begin
      errors++; $display("FAIL rst_mid_ignored: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [NRS-1:0] m;
    for (int n = 0; n < 6; n++) begin
      m = NRS'(n + 1);
      run_inst({$urandom, $urandom}, WIW'($urandom), NRS*RAW'($urandom), m, 100, 1, 100, 0, 0, lat);
      checks++;
      if (lat != 2 * $countones(m) + 1) begin
        errors++; $display("FAIL lat_b2b use=%b: got %0d required %0d", m, lat, 2 * $countones(m) + 1);
      end
    end
  endtask

  task automatic test_random;
    int lat;
    spur_pct = 20;
    for (int n = 0; n < 30; n++) begin
      run_inst({$urandom, $urandom}, WIW'($urandom), NRS*RAW'($urandom), NRS'($urandom),
               $urandom_range(100, 30), $urandom_range(4, 1), $urandom_range(100, 30), 0, 0, lat);
    end
    spur_pct = 0;
  endtask

  initial begin
    for (int w = 0; w < 16; w++)
      for (int a = 0; a < 32; a++)
        rf_mem[w][a] = junk();
    test_reset;
    test_no_operands;
    test_sparse;
    test_req_stall;
    test_out_backpressure;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gelato_operand_collector.md
GELATO_OPERAND_COLLECTOR -- requirements
Module: gelato_operand_collector

Interface
REQ-001 SHALL have parameter NUM_RS, default 3, number of source operand slots.
REQ-002 SHALL have parameter INST_W, default 64, instruction bus width.
REQ-003 SHALL have parameter REG_ADDR_W, default 5, register index width.
REQ-004 SHALL have parameter WARP_ID_W, default 4, warp id width.
REQ-005 SHALL have parameter WARP_REG_W, default 1024, width of one warp register (all lanes).
REQ-006 SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-007 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- flush  in  1  discard current instruction
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  collector accepts instruction
- in_inst  in  INST_W  instruction
- in_warp  in  WARP_ID_W  warp id
- in_rs_addr  in  NUM_RS*REG_ADDR_W  source register indices, slot i at [i*REG_ADDR_W +: REG_ADDR_W]
- in_rs_use  in  NUM_RS  slot i needs a register read
- rf_req_valid  out  1  register-file read request
- rf_req_ready  in  1  register file accepts request
- rf_req_warp  out  WARP_ID_W  warp of read
- rf_req_addr  out  REG_ADDR_W  register of read
- rf_rsp_valid  in  1  read data returned
- rf_rsp_data  in  WARP_REG_W  read data
- out_valid  out  1  instruction with operands ready for execute unit
- out_ready  in  1  execute unit consumes
- out_inst  out  INST_W  held instruction
- out_src  out  NUM_RS*WARP_REG_W  operands, slot i at [i*WARP_REG_W +: WARP_REG_W]

Function
REQ-008 SHALL implement states IDLE, REQ, WAIT, ISSUE, DRAIN.
REQ-009 SHALL drive in_ready=1 only in IDLE; acceptance = in_valid & in_ready.
REQ-010 On acceptance SHALL latch inst, warp, rs_addr, rs_use; clear all src slots to zero; go to REQ if any rs_use bit set, else ISSUE.
REQ-011 SHALL read used slots in ascending index order, exactly one read per used slot; unused slots stay zero.
REQ-012 In REQ SHALL assert rf_req_valid with warp/addr of the lowest unread used slot; on rf_req_ready go to WAIT; request fields held stable while waiting for ready.
REQ-013 SHALL have at most one register-file read outstanding.
REQ-014 In WAIT, on rf_rsp_valid SHALL write rf_rsp_data into the current slot; go to REQ if a higher used slot remains, else ISSUE.
REQ-015 SHALL ignore rf_rsp_valid in IDLE, REQ, ISSUE.
REQ-016 In ISSUE SHALL assert out_valid; out_inst/out_src stable until out_valid & out_ready; then go to IDLE.
REQ-017 Minimum latency: acceptance in cycle 0, no used slots -> out_valid in cycle 1; k used slots with rf_req_ready=1 and one-cycle response -> out_valid in cycle 2k+1.
REQ-018 flush SHALL take priority over all other events in the same cycle.
REQ-019 flush in REQ or ISSUE SHALL go to IDLE next cycle, out_valid/rf_req_valid low.
REQ-020 flush in WAIT, or flush in REQ coinciding with rf_req_ready, SHALL go to DRAIN; DRAIN holds in_ready=0 and goes to IDLE on rf_rsp_valid, data discarded.
REQ-021 flush in the same cycle as rf_rsp_valid in WAIT SHALL go to IDLE (response consumed, discarded).
REQ-022 flush in IDLE SHALL block acceptance that cycle and have no other effect.
REQ-023 out_valid & out_ready with flush same cycle: instruction counts as flushed, not issued; in_ready stays 0 that cycle.

Reset
REQ-024 While rst=1 SHALL force IDLE; in_ready=0, rf_req_valid=0, out_valid=0, out_inst=0, out_src=0, rf_req_warp=0, rf_req_addr=0, slot pointer=0.
REQ-025 Reset mid-operation SHALL abandon the instruction and any outstanding read; first cycle after release in_ready=1, and a response arriving then is ignored.

Verification
REQ-026 in_rs_use=3'b000, inst=64'hA5 accepted cycle 0, out_ready=1 -> out_valid cycle 1, out_inst=64'hA5, out_src all zero, no rf_req_valid.
REQ-027 in_rs_use=3'b101, addrs {7,_,3}, warp 2, one-cycle RF -> requests addr 3 then 7 (warp 2); slot0=data(r3), slot2=data(r7), slot1=0; out_valid cycle 5.
REQ-028 rf_req_ready held 0 for 4 cycles -> rf_req_valid/addr stable all 4 cycles; single read issued.
REQ-029 out_ready=0 for 3 cycles in ISSUE -> out_valid and data stable; in_ready=0 throughout; in_ready=1 the cycle after handshake.
REQ-030 flush in WAIT, response 2 cycles later -> DRAIN, in_ready=0 until response, then IDLE; next instruction gets fresh operands, no stale data.
REQ-031 rst asserted in WAIT, response arrives first cycle after release -> response ignored, all outputs at reset values, in_ready=1.
